// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed 7-segment scan controller.
// One shared combinational BCD decoder serves NUM_DIGITS common-anode
// positions. Host writes land in a shadow bank; the shadow bank is copied
// into the active bank only at the start of each frame, so a frame never
// shows a mix of old and new values.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | scanning stopped, all anodes off, segments blank
// BLANK  | anti-ghosting guard, anodes off, decoder input settling
// SHOW   | digit idx lit, segment pins hold the latched pattern
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int IDX_W        = 2,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [3:0]            wr_data,
  input  logic                  err_clr,
  output logic [3:0]            dec_num,
  input  logic [7:0]            dec_seg,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic [7:0]            seg_n,
  output logic                  frame_tick,
  output logic                  err
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [3:0]              shadow_q [NUM_DIGITS];
  logic [3:0]              shadow_d [NUM_DIGITS];
  logic [3:0]              active_q [NUM_DIGITS];
  logic [3:0]              active_d [NUM_DIGITS];
  logic [7:0]              seg_n_q, seg_n_d;
  logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
  logic [3:0]              dec_num_q, dec_num_d;
  logic                    frame_tick_q, frame_tick_d;
  logic                    err_q, err_d;
  logic                    commit;
  logic                    wr_idx_ok;
  logic                    wr_code_bad;

  assign wr_idx_ok   = (32'(wr_idx) < 32'(NUM_DIGITS));
  assign wr_code_bad = (wr_data >= 4'd10) && (wr_data <= 4'd14);

  // Host write path: sanitise codes into the shadow bank, track sticky error.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      shadow_d[i] = shadow_q[i];
      if (wr_en && wr_idx_ok && (wr_idx == IDX_W'(i))) begin
        shadow_d[i] = wr_code_bad ? 4'hF : wr_data;
      end
    end
    err_d = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end
    // An error-setting write wins over a simultaneous clear.
    if (wr_en && (!wr_idx_ok || wr_code_bad)) begin
      err_d = 1'b1;
    end
  end

  // Scan sequencer: next state, slot counter, digit index, segment latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    seg_n_d = seg_n_q;
    commit  = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      seg_n_d = 8'hFF;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          idx_d   = '0;
          seg_n_d = 8'hFF;
          commit  = 1'b1;
        end
        ST_BLANK: begin
          cnt_d = cnt_q + CNT_W'(1);
          // dec_num has been stable since the first BLANK cycle.
          if (cnt_q == BLANK_LAST) begin
            seg_n_d = dec_seg;
            state_d = ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_BLANK;
            if (idx_q == IDX_LAST) begin
              idx_d  = '0;
              commit = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
          seg_n_d = 8'hFF;
        end
      endcase
    end
  end

  // Frame commit and pin drivers, all derived from the next state so the
  // registered pins line up with the state register.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      active_d[i] = commit ? shadow_d[i] : active_q[i];
    end
    dec_num_d = 4'hF;
    if (state_d != ST_IDLE) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx_d == IDX_W'(i)) begin
          dec_num_d = active_d[i];
        end
      end
    end
    an_n_d = '1;
    if (state_d == ST_SHOW) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx_d == IDX_W'(i)) begin
          an_n_d[i] = 1'b0;
        end
      end
    end
    frame_tick_d = commit;
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '{default: 4'hF};
      active_q     <= '{default: 4'hF};
      seg_n_q      <= 8'hFF;
      an_n_q       <= '1;
      dec_num_q    <= 4'hF;
      frame_tick_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      seg_n_q      <= seg_n_d;
      an_n_q       <= an_n_d;
      dec_num_q    <= dec_num_d;
      frame_tick_q <= frame_tick_d;
      err_q        <= err_d;
    end
  end

  assign dec_num    = dec_num_q;
  assign an_n       = an_n_q;
  assign seg_n      = seg_n_q;
  assign frame_tick = frame_tick_q;
  assign err        = err_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with SCAN_DIV=8, BLANK_CYCLES=2,
// NUM_DIGITS=4, IDX_W=3, and a behavioural active-low 7-segment decoder
// (bit order dp,a,b,c,d,e,f,g).
module tb_seg_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       wr_en;
  logic [2:0] wr_idx;
  logic [3:0] wr_data;
  logic       err_clr;
  logic [3:0] dec_num;
  logic [7:0] dec_seg;
  logic [3:0] an_n;
  logic [7:0] seg_n;
  logic       frame_tick;
  logic       err;

  int vectors     = 0;
  int miscompares = 0;
  bit mon_en      = 0;

  seg_scan_ctrl #(
    .NUM_DIGITS  (4),
    .IDX_W       (3),
    .SCAN_DIV    (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data),
    .err_clr   (err_clr),
    .dec_num   (dec_num),
    .dec_seg   (dec_seg),
    .an_n      (an_n),
    .seg_n     (seg_n),
    .frame_tick(frame_tick),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (dec_num)
      4'd0:    dec_seg = 8'h81;
      4'd1:    dec_seg = 8'hCF;
      4'd2:    dec_seg = 8'h92;
      4'd3:    dec_seg = 8'h86;
      4'd4:    dec_seg = 8'hCC;
      4'd5:    dec_seg = 8'hA4;
      4'd6:    dec_seg = 8'hA0;
      4'd7:    dec_seg = 8'h8F;
      4'd8:    dec_seg = 8'h80;
      4'd9:    dec_seg = 8'h84;
      default: dec_seg = 8'hFF;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // The decoder must never be handed a code in 10..14.
  always @(negedge clk) begin
    if (mon_en) chk("dec_num_legal", 32'((dec_num < 4'd10) || (dec_num == 4'hF)), 32'd1);
  end

  task automatic chk_idle();
    chk("idle_an_n", 32'(an_n), 32'hF);
    chk("idle_seg_n", 32'(seg_n), 32'hFF);
    chk("idle_dec_num", 32'(dec_num), 32'hF);
    chk("idle_frame_tick", 32'(frame_tick), 32'd0);
  endtask

  // One full frame starting at the commit edge. Optionally pulses a write
  // during the first SHOW cycle of digit wd.
  task automatic run_frame(input logic [7:0] s0, input logic [7:0] s1,
                           input logic [7:0] s2, input logic [7:0] s3,
                           input int wd, input logic [2:0] wi, input logic [3:0] wv);
    logic [7:0] exp_seg [4];
    logic [3:0] exp_an;
    exp_seg[0] = s0; exp_seg[1] = s1; exp_seg[2] = s2; exp_seg[3] = s3;
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        chk($sformatf("blank_an_n_d%0d_c%0d", d, c), 32'(an_n), 32'hF);
        chk($sformatf("frame_tick_d%0d_c%0d", d, c), 32'(frame_tick),
            32'((d == 0) && (c == 0)));
      end
      exp_an = ~(4'b0001 << d);
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (d == wd && c == 1) wr_en = 1'b0;
        chk($sformatf("show_an_n_d%0d_c%0d", d, c), 32'(an_n), 32'(exp_an));
        chk($sformatf("show_seg_n_d%0d_c%0d", d, c), 32'(seg_n), 32'(exp_seg[d]));
        chk($sformatf("show_tick_d%0d_c%0d", d, c), 32'(frame_tick), 32'd0);
        if (d == wd && c == 0) begin
          wr_en = 1'b1; wr_idx = wi; wr_data = wv;
        end
      end
    end
  endtask

  task automatic write1(input logic [2:0] wi, input logic [3:0] wv);
    wr_en = 1'b1; wr_idx = wi; wr_data = wv;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_data = '0; err_clr = 1'b0;

    // Reset held for three cycles.
    repeat (3) @(negedge clk);
    mon_en = 1;
    chk_idle();
    chk("reset_err", 32'(err), 32'd0);

    // Blank frame with nothing written.
    rst = 1'b1; enable = 1'b1;
    run_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, -1, 3'd0, 4'd0);
    enable = 1'b0;
    @(negedge clk);
    chk_idle();

    // Digits 1,2,3,4 written while idle.
    write1(3'd0, 4'd1);
    write1(3'd1, 4'd2);
    write1(3'd2, 4'd3);
    write1(3'd3, 4'd4);
    chk("legal_writes_err", 32'(err), 32'd0);
    chk_idle();
    enable = 1'b1;
    run_frame(8'hCF, 8'h92, 8'h86, 8'hCC, -1, 3'd0, 4'd0);
    // Mid-frame write of 9 to digit 2 while digit 1 is lit.
    run_frame(8'hCF, 8'h92, 8'h86, 8'hCC, 1, 3'd2, 4'd9);
    run_frame(8'hCF, 8'h92, 8'h84, 8'hCC, -1, 3'd0, 4'd0);
    enable = 1'b0;
    @(negedge clk);
    chk_idle();

    // Illegal code, clear, clear racing an error write, illegal index.
    write1(3'd0, 4'hB);
    chk("bad_code_err", 32'(err), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", 32'(err), 32'd0);
    err_clr = 1'b1;
    write1(3'd7, 4'd1);
    err_clr = 1'b0;
    chk("err_clr_vs_set", 32'(err), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr2", 32'(err), 32'd0);
    write1(3'd5, 4'd7);
    chk("bad_idx_err", 32'(err), 32'd1);

    // Re-enable with a write landing on the commit edge.
    enable = 1'b1; wr_en = 1'b1; wr_idx = 3'd3; wr_data = 4'd7;
    run_frame(8'hFF, 8'h92, 8'h84, 8'h8F, 0, 3'd3, 4'd7);
    chk("err_sticky", 32'(err), 32'd1);

    // Drop enable during SHOW of digit 2, then restart.
    repeat (19) @(negedge clk);
    chk("pre_drop_an_n", 32'(an_n), 32'hB);
    chk("pre_drop_seg_n", 32'(seg_n), 32'h84);
    enable = 1'b0;
    @(negedge clk);
    chk_idle();
    enable = 1'b1;
    run_frame(8'hFF, 8'h92, 8'h84, 8'h8F, -1, 3'd0, 4'd0);

    // Reset during SHOW of digit 2 with err set beforehand.
    write1(3'd6, 4'd1);
    repeat (18) @(negedge clk);
    chk("pre_rst_an_n", 32'(an_n), 32'hB);
    chk("pre_rst_err", 32'(err), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk_idle();
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b1;
    run_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, -1, 3'd0, 4'd0);

    mon_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
